// File: rtl/ifetch_seq.sv
// Instruction-fetch sequencer: holds the fetch PC, waits WAIT_CYCLES for the EEPROM ROM to settle,
// latches the word and offers it to decode. Optional build macro: IFETCH_MISALIGN_TRAP_EN.
module ifetch_seq #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault
);

    localparam logic [3:0]  CNT_LAST = 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic [31:0] pc;
    logic [3:0]  cnt;
    logic        halted;
    logic        settled;
    logic        slot_free;
    logic        take;

    // Sequential fetch address; wraps silently at the top of the address space.
    function automatic logic [31:0] pc_inc(input logic [31:0] cur);
        return cur + 32'd4;
    endfunction

    function automatic logic [31:0] redirect_target(input logic [31:0] tgt);
`ifdef IFETCH_MISALIGN_TRAP_EN
        return tgt;
`else
        return tgt & ~32'h0000_0003;
`endif
    endfunction

    assign rom_addr  = pc;
    assign settled   = (cnt == CNT_LAST);
    assign slot_free = !inst_valid || inst_ready;
    assign take      = settled && slot_free && !redirect_valid && !halted;

`ifndef IFETCH_MISALIGN_TRAP_EN
    assign halted     = 1'b0;
    assign inst_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            cnt        <= '0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            inst_fault <= 1'b0;
            halted     <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // A handshake in the same cycle is consumed; the flushed fetch never appears.
            pc         <= redirect_target(redirect_pc);
            cnt        <= '0;
            inst_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            halted     <= 1'b0;
`endif
        end else if (take) begin
            cnt        <= '0;
            inst_valid <= 1'b1;
            inst_pc    <= pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
            if (pc[1:0] != 2'b00) begin
                inst       <= NOP;
                inst_fault <= 1'b1;
                halted     <= 1'b1;
            end else begin
                inst       <= rom_inst;
                inst_fault <= 1'b0;
                pc         <= pc_inc(pc);
            end
`else
            inst       <= rom_inst;
            pc         <= pc_inc(pc);
`endif
        end else begin
            if (!settled) begin
                cnt <= cnt + 4'd1;
            end
            if (inst_valid && inst_ready) begin
                inst_valid <= 1'b0;
            end
        end
    end

endmodule
